// File: rtl/riscv_imem_responder.sv
// riscv_imem_responder
// Instruction-memory responder sitting at the far end of the fetch path.
// A fetch PC is accepted through a valid/ready handshake, the addressed word
// travels down a fixed LATENCY-stage pipeline and lands in a small
// first-word-fall-through response FIFO that absorbs fetch backpressure.
// A flush discards everything in flight. A word-wide loader port preloads
// program memory.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_valid/o_req_ready      fetch request handshake
//   i_req_addr                   byte address (PC) of the request
//   i_flush                      drop all in-flight and buffered responses
//   o_rsp_valid/i_rsp_ready      response handshake
//   o_rsp_instr/addr/err         response payload (err: misaligned/out of range)
//   i_ld_we/i_ld_addr/i_ld_data  loader word write port
module riscv_imem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [XLEN-1:0]              i_req_addr,
  input  logic                         i_flush,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [XLEN-1:0]              o_rsp_instr,
  output logic [XLEN-1:0]              o_rsp_addr,
  output logic                         o_rsp_err,
  input  logic                         i_ld_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_ld_addr,
  input  logic [XLEN-1:0]              i_ld_data
);

  localparam int AW        = $clog2(MEM_DEPTH);
  localparam int RSP_DEPTH = LATENCY + 1;
  localparam int PW        = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW        = $clog2(RSP_DEPTH + 1);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0]    r_mem [MEM_DEPTH];

  logic [LATENCY-1:0] r_stgValid;
  logic [LATENCY-1:0] r_stgErr;
  logic [XLEN-1:0]    r_stgAddr  [LATENCY];
  logic [XLEN-1:0]    r_stgInstr [LATENCY];

  logic [XLEN-1:0]    r_fifoInstr [RSP_DEPTH];
  logic [XLEN-1:0]    r_fifoAddr  [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] r_fifoErr;
  logic [PW-1:0]      r_wrPtr;
  logic [PW-1:0]      r_rdPtr;
  logic [CW-1:0]      r_fifoCnt;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_err;
  logic [AW-1:0]      w_idx;
  logic [XLEN-1:0]    w_instr;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both the pipeline and the FIFO, so a full FIFO can never
  // be pushed. Upper address bits being nonzero means the word index is
  // beyond MEM_DEPTH; such requests are never aliased onto real memory.
  assign o_req_ready = !i_rst && !i_flush && (r_cnt < CW'(RSP_DEPTH));
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_idx       = i_req_addr[AW+1:2];
  assign w_err       = (i_req_addr[1:0] != 2'b00) || (i_req_addr[XLEN-1:AW+2] != '0);
  assign w_instr     = w_err ? NOP : r_mem[w_idx];
  assign w_push      = r_stgValid[LATENCY-1];
  assign w_pop       = o_rsp_valid && i_rsp_ready;

  // FIFO storage is not reset, so the head is gated to zero when empty.
  assign o_rsp_valid = (r_fifoCnt != '0);
  assign o_rsp_instr = o_rsp_valid ? r_fifoInstr[r_rdPtr] : '0;
  assign o_rsp_addr  = o_rsp_valid ? r_fifoAddr[r_rdPtr]  : '0;
  assign o_rsp_err   = o_rsp_valid && r_fifoErr[r_rdPtr];

  // Loader write; the fetch read above sees the pre-write contents.
  always_ff @(posedge i_clk) begin
    if (i_ld_we) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
  end

  // Fixed-latency shift pipeline; it never stalls because credits
  // guarantee room in the FIFO for every word that reaches the end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stgValid <= '0;
      r_stgErr   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_stgAddr[i]  <= '0;
        r_stgInstr[i] <= '0;
      end
    end else if (i_flush) begin
      r_stgValid <= '0;
    end else begin
      r_stgValid[0] <= w_accept;
      r_stgErr[0]   <= w_err;
      r_stgAddr[0]  <= i_req_addr;
      r_stgInstr[0] <= w_instr;
      for (int i = 1; i < LATENCY; i++) begin
        r_stgValid[i] <= r_stgValid[i-1];
        r_stgErr[i]   <= r_stgErr[i-1];
        r_stgAddr[i]  <= r_stgAddr[i-1];
        r_stgInstr[i] <= r_stgInstr[i-1];
      end
    end
  end

  // Response FIFO payload.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_fifoInstr[r_wrPtr] <= r_stgInstr[LATENCY-1];
      r_fifoAddr[r_wrPtr]  <= r_stgAddr[LATENCY-1];
      r_fifoErr[r_wrPtr]   <= r_stgErr[LATENCY-1];
    end
  end

  // FIFO pointers and occupancy; a flush empties it in one edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_fifoCnt <= '0;
    end else if (i_flush) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_fifoCnt <= '0;
    end else begin
      if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_push, w_pop})
        2'b10:   r_fifoCnt <= r_fifoCnt + CW'(1);
        2'b01:   r_fifoCnt <= r_fifoCnt - CW'(1);
        default: r_fifoCnt <= r_fifoCnt;
      endcase
    end
  end

  // Outstanding-response credit counter (pipeline plus FIFO).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_imem_responder.sv
// tb_riscv_imem_responder
// Directed bench for riscv_imem_responder with LATENCY=2, MEM_DEPTH=1024.
module tb_riscv_imem_responder;

  localparam int XLEN      = 32;
  localparam int MEM_DEPTH = 1024;
  localparam int AW        = $clog2(MEM_DEPTH);

  logic            clk = 1'b0;
  logic            rst;
  logic            reqValid;
  logic            reqReady;
  logic [XLEN-1:0] reqAddr;
  logic            flush;
  logic            rspValid;
  logic            rspReady;
  logic [XLEN-1:0] rspInstr;
  logic [XLEN-1:0] rspAddr;
  logic            rspErr;
  logic            ldWe;
  logic [AW-1:0]   ldAddr;
  logic [XLEN-1:0] ldData;

  int checks = 0;
  int errors = 0;

  riscv_imem_responder #(.XLEN(XLEN), .MEM_DEPTH(MEM_DEPTH), .LATENCY(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_addr  (reqAddr),
    .i_flush     (flush),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_instr (rspInstr),
    .o_rsp_addr  (rspAddr),
    .o_rsp_err   (rspErr),
    .i_ld_we     (ldWe),
    .i_ld_addr   (ldAddr),
    .i_ld_data   (ldData)
  );

  // Free-running clock; rising edge is active.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] addr, input logic err);
    checkOutput({tag, ".valid"}, {31'd0, rspValid}, {31'd0, v});
    if (v) begin
      checkOutput({tag, ".instr"}, rspInstr, instr);
      checkOutput({tag, ".addr"}, rspAddr, addr);
      checkOutput({tag, ".err"}, {31'd0, rspErr}, {31'd0, err});
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rr);
    reqValid = v;
    reqAddr  = a;
    rspReady = rr;
  endtask

  task automatic loadWord(input int idx, input logic [31:0] d);
    ldWe   = 1'b1;
    ldAddr = AW'(idx);
    ldData = d;
    tick();
    ldWe   = 1'b0;
  endtask

  // Directed sequence; all expected values are hand-derived cycle by cycle.
  initial begin
    rst = 1'b1; flush = 1'b0; ldWe = 1'b0; ldAddr = '0; ldData = '0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rst.reqReady", {31'd0, reqReady}, 32'd0);
    checkOutput("rst.rspValid", {31'd0, rspValid}, 32'd0);
    checkOutput("rst.rspInstr", rspInstr, 32'd0);
    checkOutput("rst.rspAddr", rspAddr, 32'd0);
    checkOutput("rst.rspErr", {31'd0, rspErr}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("postRst.reqReady", {31'd0, reqReady}, 32'd1);

    loadWord(0, 32'h11); loadWord(1, 32'h22); loadWord(2, 32'h33);
    loadWord(3, 32'h44); loadWord(5, 32'h55);

    // Back-to-back fetches; credits run out after three and cause a bubble.
    applyStimulus(1'b1, 32'h0, 1'b1); tick();
    checkRsp("t1.e0", 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 32'h4, 1'b1); tick();
    checkRsp("t1.e1", 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 32'h8, 1'b1); tick();
    checkRsp("t1.e2", 1'b1, 32'h11, 32'h0, 1'b0);
    checkOutput("t1.e2.reqReady", {31'd0, reqReady}, 32'd0);
    applyStimulus(1'b1, 32'hC, 1'b1); tick();
    checkRsp("t1.e3", 1'b1, 32'h22, 32'h4, 1'b0);
    checkOutput("t1.e3.reqReady", {31'd0, reqReady}, 32'd1);
    tick();
    checkRsp("t1.e4", 1'b1, 32'h33, 32'h8, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1); tick();
    checkRsp("t1.e5", 1'b0, 0, 0, 0);
    tick();
    checkRsp("t1.e6", 1'b1, 32'h44, 32'hC, 1'b0);
    tick();
    checkRsp("t1.e7", 1'b0, 0, 0, 0);

    // Backpressure: only three requests fit, outputs hold while stalled.
    applyStimulus(1'b1, 32'h0, 1'b0); tick();
    applyStimulus(1'b1, 32'h4, 1'b0); tick();
    applyStimulus(1'b1, 32'h8, 1'b0); tick();
    checkOutput("t2.full.reqReady", {31'd0, reqReady}, 32'd0);
    checkRsp("t2.e2", 1'b1, 32'h11, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0); tick(); tick();
    checkOutput("t2.e4.reqReady", {31'd0, reqReady}, 32'd0);
    checkRsp("t2.e4", 1'b1, 32'h11, 32'h0, 1'b0);
    tick();
    checkRsp("t2.e5", 1'b1, 32'h11, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1); tick();
    checkRsp("t2.e6", 1'b1, 32'h22, 32'h4, 1'b0);
    checkOutput("t2.e6.reqReady", {31'd0, reqReady}, 32'd1);
    tick();
    checkRsp("t2.e7", 1'b1, 32'h33, 32'h8, 1'b0);
    tick();
    checkRsp("t2.e8", 1'b0, 0, 0, 0);

    // Misaligned and out-of-range requests.
    applyStimulus(1'b1, 32'h2, 1'b1); tick();
    applyStimulus(1'b1, 32'h1000, 1'b1); tick();
    applyStimulus(1'b0, 32'h0, 1'b1); tick();
    checkRsp("t3.misalign", 1'b1, 32'h13, 32'h2, 1'b1);
    tick();
    checkRsp("t3.range", 1'b1, 32'h13, 32'h1000, 1'b1);
    tick();
    checkRsp("t3.drain", 1'b0, 0, 0, 0);

    // Flush with two requests in flight.
    applyStimulus(1'b1, 32'h0, 1'b1); tick();
    applyStimulus(1'b1, 32'h4, 1'b1); tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("t4.flush.reqReady", {31'd0, reqReady}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    checkRsp("t4.f1", 1'b0, 0, 0, 0);
    checkOutput("t4.after.reqReady", {31'd0, reqReady}, 32'd1);
    tick();
    checkRsp("t4.f2", 1'b0, 0, 0, 0);
    tick();
    checkRsp("t4.f3", 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 32'h8, 1'b1); tick();
    applyStimulus(1'b0, 32'h0, 1'b1); tick();
    checkRsp("t4.r1", 1'b0, 0, 0, 0);
    tick();
    checkRsp("t4.r2", 1'b1, 32'h33, 32'h8, 1'b0);
    tick();
    checkRsp("t4.r3", 1'b0, 0, 0, 0);

    // Read-before-write on a same-cycle loader write.
    ldWe = 1'b1; ldAddr = AW'(5); ldData = 32'hAA;
    applyStimulus(1'b1, 32'h14, 1'b1); tick();
    ldWe = 1'b0;
    applyStimulus(1'b1, 32'h14, 1'b1); tick();
    applyStimulus(1'b0, 32'h0, 1'b1); tick();
    checkRsp("t5.old", 1'b1, 32'h55, 32'h14, 1'b0);
    tick();
    checkRsp("t5.new", 1'b1, 32'hAA, 32'h14, 1'b0);
    tick();
    checkRsp("t5.drain", 1'b0, 0, 0, 0);

    // Asynchronous reset mid-cycle with two responses outstanding.
    applyStimulus(1'b1, 32'h0, 1'b0); tick();
    applyStimulus(1'b1, 32'h4, 1'b0); tick();
    applyStimulus(1'b0, 32'h0, 1'b0); tick();
    checkRsp("t6.pre", 1'b1, 32'h11, 32'h0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t6.rst.rspValid", {31'd0, rspValid}, 32'd0);
    checkOutput("t6.rst.reqReady", {31'd0, reqReady}, 32'd0);
    checkOutput("t6.rst.rspInstr", rspInstr, 32'd0);
    tick();
    rst = 1'b0;
    rspReady = 1'b1;
    #1;
    checkOutput("t6.rel.reqReady", {31'd0, reqReady}, 32'd1);
    tick();
    checkRsp("t6.s1", 1'b0, 0, 0, 0);
    tick();
    checkRsp("t6.s2", 1'b0, 0, 0, 0);
    tick();
    checkRsp("t6.s3", 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 32'hC, 1'b1); tick();
    applyStimulus(1'b0, 32'h0, 1'b1); tick(); tick();
    checkRsp("t6.fresh", 1'b1, 32'h44, 32'hC, 1'b0);
    tick();
    checkRsp("t6.end", 1'b0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
